// File: rtl/costas_lock_sequencer_if.sv
// Loop-error sample stream from the Costas error-detect mux into the lock sequencer.
interface costas_lock_sequencer_if #(
    parameter int WIDTH = 16
);
    logic signed [WIDTH-1:0] error_tdata;
    logic                    error_tvalid;

    modport master (output error_tdata, output error_tvalid);
    modport slave  (input  error_tdata, input  error_tvalid);
endinterface

// File: rtl/costas_lock_sequencer.sv
// Costas-loop lock sequencer: owns mode select and datapath flush, declares lock,
// detects loss of lock and times out failed acquisitions.
module costas_lock_sequencer #(
    parameter int WIDTH        = 16,
    parameter int FLUSH_CYCLES = 16,
    parameter int LOCK_THRESH  = 1024,
    parameter int LOCK_COUNT   = 256,
    parameter int UNLOCK_COUNT = 64,
    parameter int ACQ_TIMEOUT  = 65536,
    parameter int CNT_WIDTH    = 17
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode_req,
    input  logic                     restart,
    costas_lock_sequencer_if.slave   err,
    output logic                     is_bpsk,
    output logic                     loop_rst,
    output logic                     locked,
    output logic [1:0]               state,
    output logic                     acq_fail,
    output logic [7:0]               retry_cnt
);

    typedef enum logic [1:0] {
        ST_FLUSH   = 2'b00,
        ST_ACQUIRE = 2'b01,
        ST_LOCKED  = 2'b10
    } state_t;

    localparam logic [CNT_WIDTH-1:0] FLUSH_LAST  = CNT_WIDTH'(FLUSH_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LOCK_LAST   = CNT_WIDTH'(LOCK_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] UNLOCK_LAST = CNT_WIDTH'(UNLOCK_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] TMO_LAST    = CNT_WIDTH'(ACQ_TIMEOUT - 1);
    localparam logic [WIDTH:0]       THRESH      = (WIDTH + 1)'(LOCK_THRESH);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  tmr_q, tmr_d;
    logic [CNT_WIDTH-1:0]  run_q, run_d;
    logic                  is_bpsk_q, is_bpsk_d;
    logic                  acq_fail_q, acq_fail_d;
    logic [7:0]            retry_q, retry_d;

    logic signed [WIDTH:0] err_ext;
    logic [WIDTH:0]        err_mag;
    logic                  good;
    logic                  reflush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FLUSH;
            tmr_q      <= '0;
            run_q      <= '0;
            is_bpsk_q  <= 1'b1;
            acq_fail_q <= 1'b0;
            retry_q    <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            run_q      <= run_d;
            is_bpsk_q  <= is_bpsk_d;
            acq_fail_q <= acq_fail_d;
            retry_q    <= retry_d;
        end
    end

    // Magnitude is taken one bit wider so the most negative sample cannot wrap to "small".
    always_comb begin
        err_ext    = {err.error_tdata[WIDTH-1], err.error_tdata};
        err_mag    = err_ext[WIDTH] ? $unsigned(-err_ext) : $unsigned(err_ext);
        good       = (err_mag < THRESH);
        reflush    = restart || (mode_req != is_bpsk_q);

        state_d    = state_q;
        tmr_d      = tmr_q;
        run_d      = run_q;
        is_bpsk_d  = is_bpsk_q;
        acq_fail_d = 1'b0;
        retry_d    = retry_q;

        if (reflush) begin
            state_d   = ST_FLUSH;
            is_bpsk_d = mode_req;
            tmr_d     = '0;
            run_d     = '0;
        end else begin
            case (state_q)
                ST_ACQUIRE: begin
                    tmr_d = tmr_q + 1'b1;
                    if (err.error_tvalid) begin
                        run_d = good ? run_q + 1'b1 : '0;
                    end
                    // A lock on the final timeout cycle takes precedence over the retry.
                    if (err.error_tvalid && good && run_q == LOCK_LAST) begin
                        state_d = ST_LOCKED;
                        tmr_d   = '0;
                        run_d   = '0;
                    end else if (tmr_q == TMO_LAST) begin
                        state_d    = ST_FLUSH;
                        tmr_d      = '0;
                        run_d      = '0;
                        acq_fail_d = 1'b1;
                        if (retry_q != 8'hFF) begin
                            retry_d = retry_q + 8'd1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (err.error_tvalid) begin
                        run_d = good ? '0 : run_q + 1'b1;
                        if (!good && run_q == UNLOCK_LAST) begin
                            state_d = ST_ACQUIRE;
                            tmr_d   = '0;
                            run_d   = '0;
                        end
                    end
                end
                default: begin
                    tmr_d = tmr_q + 1'b1;
                    run_d = '0;
                    if (tmr_q == FLUSH_LAST) begin
                        state_d = ST_ACQUIRE;
                        tmr_d   = '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        loop_rst = 1'b1;
        locked   = 1'b0;
        state    = 2'b00;
        case (state_q)
            ST_ACQUIRE: begin
                loop_rst = 1'b0;
                state    = 2'b01;
            end
            ST_LOCKED: begin
                loop_rst = 1'b0;
                locked   = 1'b1;
                state    = 2'b10;
            end
            default: ;
        endcase
    end

    assign is_bpsk   = is_bpsk_q;
    assign acq_fail  = acq_fail_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_costas_lock_sequencer.sv
// Directed bench for costas_lock_sequencer: vector table for the lock/unlock/flush
// walk plus hand sequences for timeout, lock/timeout tie, async reset and saturation.
module tb_costas_lock_sequencer;

    localparam logic [1:0] S_FLUSH = 2'b00;
    localparam logic [1:0] S_ACQ   = 2'b01;
    localparam logic [1:0] S_LCK   = 2'b10;

    logic       clk;
    logic       rst_n;
    logic       mode_req;
    logic       restart;
    logic       is_bpsk;
    logic       loop_rst;
    logic       locked;
    logic [1:0] state;
    logic       acq_fail;
    logic [7:0] retry_cnt;

    logic       rst2_n;
    logic       is_bpsk2;
    logic       loop_rst2;
    logic       locked2;
    logic [1:0] state2;
    logic       acq_fail2;
    logic [7:0] retry_cnt2;

    int n_cmp;
    int n_fail;

    costas_lock_sequencer_if #(.WIDTH(16)) err_if ();
    costas_lock_sequencer_if #(.WIDTH(16)) err2_if ();

    costas_lock_sequencer #(
        .WIDTH(16), .FLUSH_CYCLES(16), .LOCK_THRESH(1024), .LOCK_COUNT(256),
        .UNLOCK_COUNT(64), .ACQ_TIMEOUT(1024), .CNT_WIDTH(11)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode_req(mode_req), .restart(restart),
        .err(err_if), .is_bpsk(is_bpsk), .loop_rst(loop_rst), .locked(locked),
        .state(state), .acq_fail(acq_fail), .retry_cnt(retry_cnt)
    );

    // Short flush and timeout so hundreds of retries fit in a few thousand cycles.
    costas_lock_sequencer #(
        .WIDTH(16), .FLUSH_CYCLES(2), .LOCK_THRESH(1024), .LOCK_COUNT(256),
        .UNLOCK_COUNT(64), .ACQ_TIMEOUT(8), .CNT_WIDTH(9)
    ) dut_sat (
        .clk(clk), .rst_n(rst2_n), .mode_req(1'b1), .restart(1'b0),
        .err(err2_if), .is_bpsk(is_bpsk2), .loop_rst(loop_rst2), .locked(locked2),
        .state(state2), .acq_fail(acq_fail2), .retry_cnt(retry_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        string             name;
        logic              mode;
        logic              rst_pulse;
        logic signed [15:0] data;
        logic              valid;
        int                cycles;
        logic [1:0]        exp_state;
        logic              exp_bpsk;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic mode, logic rp, int data, logic valid,
                                int cycles, logic [1:0] st, logic bpsk);
        vec_t v;
        v.name      = name;
        v.mode      = mode;
        v.rst_pulse = rp;
        v.data      = 16'(data);
        v.valid     = valid;
        v.cycles    = cycles;
        v.exp_state = st;
        v.exp_bpsk  = bpsk;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(logic mode, logic rp, int data, logic valid, int cycles);
        mode_req               = mode;
        restart                = rp;
        err_if.error_tdata     = 16'(data);
        err_if.error_tvalid    = valid;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic check_output(string name, logic [1:0] st, logic bpsk, logic af, logic [7:0] rc);
        check({name, ".state"},     32'(state),     32'(st));
        check({name, ".loop_rst"},  32'(loop_rst),  32'(st == S_FLUSH));
        check({name, ".locked"},    32'(locked),    32'(st == S_LCK));
        check({name, ".is_bpsk"},   32'(is_bpsk),   32'(bpsk));
        check({name, ".acq_fail"},  32'(acq_fail),  32'(af));
        check({name, ".retry_cnt"}, 32'(retry_cnt), 32'(rc));
    endtask

    initial begin
        int n;
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        mode_req = 1'b1;
        restart  = 1'b0;
        err_if.error_tdata   = '0;
        err_if.error_tvalid  = 1'b0;
        err2_if.error_tdata  = '0;
        err2_if.error_tvalid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset", S_FLUSH, 1'b1, 1'b0, 8'd0);

        rst_n = 1'b1;
        n = 0;
        while (loop_rst && n < 100) begin
            n++;
            check({"flush_acq_fail"}, 32'(acq_fail), 32'd0);
            apply_stimulus(1'b1, 1'b0, 0, 1'b0, 1);
        end
        check("flush_len", 32'(n), 32'd16);
        check_output("first_acq", S_ACQ, 1'b1, 1'b0, 8'd0);

        vecs.push_back(mk("lock_255",     1, 0,    100, 1, 255, S_ACQ,   1));
        vecs.push_back(mk("lock_256",     1, 0,    100, 1,   1, S_LCK,   1));
        vecs.push_back(mk("bad_63",       1, 0,   5000, 1,  63, S_LCK,   1));
        vecs.push_back(mk("good_clears",  1, 0,     50, 1,   1, S_LCK,   1));
        vecs.push_back(mk("bad_63b",      1, 0,   5000, 1,  63, S_LCK,   1));
        vecs.push_back(mk("bad_64",       1, 0,   5000, 1,   1, S_ACQ,   1));
        vecs.push_back(mk("pre_200",      1, 0,    100, 1, 200, S_ACQ,   1));
        vecs.push_back(mk("neg_2000",     1, 0,  -2000, 1,   1, S_ACQ,   1));
        vecs.push_back(mk("post_255",     1, 0,    100, 1, 255, S_ACQ,   1));
        vecs.push_back(mk("post_256",     1, 0,    100, 1,   1, S_LCK,   1));
        vecs.push_back(mk("unlock_a",     1, 0,   5000, 1,  64, S_ACQ,   1));
        vecs.push_back(mk("run_100",      1, 0,    100, 1, 100, S_ACQ,   1));
        vecs.push_back(mk("idle_50",      1, 0,   5000, 0,  50, S_ACQ,   1));
        vecs.push_back(mk("run_155",      1, 0,    100, 1, 155, S_ACQ,   1));
        vecs.push_back(mk("run_156",      1, 0,    100, 1,   1, S_LCK,   1));
        vecs.push_back(mk("unlock_b",     1, 0,   5000, 1,  64, S_ACQ,   1));
        vecs.push_back(mk("pre_200b",     1, 0,    100, 1, 200, S_ACQ,   1));
        vecs.push_back(mk("neg_max",      1, 0, -32768, 1,   1, S_ACQ,   1));
        vecs.push_back(mk("post_255b",    1, 0,    100, 1, 255, S_ACQ,   1));
        vecs.push_back(mk("post_256b",    1, 0,    100, 1,   1, S_LCK,   1));
        vecs.push_back(mk("qpsk_req",     0, 0,    100, 1,   1, S_FLUSH, 0));
        vecs.push_back(mk("flush_9",      0, 0,      0, 0,   9, S_FLUSH, 0));
        vecs.push_back(mk("bpsk_back",    1, 0,      0, 0,   1, S_FLUSH, 1));
        vecs.push_back(mk("flush_15",     1, 0,      0, 0,  15, S_FLUSH, 1));
        vecs.push_back(mk("flush_16",     1, 0,      0, 0,   1, S_ACQ,   1));
        vecs.push_back(mk("thr_1023",     1, 0,   1023, 1,  10, S_ACQ,   1));
        vecs.push_back(mk("thr_1024",     1, 0,   1024, 1,   1, S_ACQ,   1));
        vecs.push_back(mk("thr_m1023",    1, 0,  -1023, 1, 255, S_ACQ,   1));
        vecs.push_back(mk("thr_lock",     1, 0,    100, 1,   1, S_LCK,   1));
        vecs.push_back(mk("restart",      1, 1,    100, 1,   1, S_FLUSH, 1));
        vecs.push_back(mk("restart_fl15", 1, 0,    100, 1,  15, S_FLUSH, 1));
        vecs.push_back(mk("restart_fl16", 1, 0,    100, 1,   1, S_ACQ,   1));

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].mode, vecs[i].rst_pulse, int'(vecs[i].data),
                           vecs[i].valid, vecs[i].cycles);
            check_output(vecs[i].name, vecs[i].exp_state, vecs[i].exp_bpsk, 1'b0, 8'd0);
        end

        // Valid toggling: only the 256 valid samples count, idle cycles hold the run.
        for (int i = 0; i < 255; i++) begin
            apply_stimulus(1'b1, 1'b0, 100, 1'b1, 1);
            apply_stimulus(1'b1, 1'b0, 5000, 1'b0, 1);
        end
        check_output("toggle_255", S_ACQ, 1'b1, 1'b0, 8'd0);
        apply_stimulus(1'b1, 1'b0, 100, 1'b1, 1);
        check_output("toggle_256", S_LCK, 1'b1, 1'b0, 8'd0);

        apply_stimulus(1'b1, 1'b1, 0, 1'b0, 1);
        apply_stimulus(1'b1, 1'b0, 0, 1'b0, 16);
        check_output("pre_timeout", S_ACQ, 1'b1, 1'b0, 8'd0);

        apply_stimulus(1'b1, 1'b0, 3000, 1'b1, 1023);
        check_output("tmo_1023", S_ACQ, 1'b1, 1'b0, 8'd0);
        apply_stimulus(1'b1, 1'b0, 3000, 1'b1, 1);
        check_output("tmo_fire", S_FLUSH, 1'b1, 1'b1, 8'd1);
        apply_stimulus(1'b1, 1'b0, 3000, 1'b1, 1);
        check_output("tmo_pulse_end", S_FLUSH, 1'b1, 1'b0, 8'd1);
        apply_stimulus(1'b1, 1'b0, 3000, 1'b1, 15);
        check_output("tmo_reacq", S_ACQ, 1'b1, 1'b0, 8'd1);

        // Lock completes on exactly the timeout cycle: lock must win.
        apply_stimulus(1'b1, 1'b0, 5000, 1'b0, 768);
        apply_stimulus(1'b1, 1'b0, 100, 1'b1, 255);
        check_output("tie_pre", S_ACQ, 1'b1, 1'b0, 8'd1);
        apply_stimulus(1'b1, 1'b0, 100, 1'b1, 1);
        check_output("tie_lock", S_LCK, 1'b1, 1'b0, 8'd1);

        apply_stimulus(1'b0, 1'b0, 0, 1'b0, 1);
        check_output("qpsk_flush", S_FLUSH, 1'b0, 1'b0, 8'd1);
        apply_stimulus(1'b0, 1'b0, 0, 1'b0, 16);
        check_output("qpsk_acq", S_ACQ, 1'b0, 1'b0, 8'd1);
        apply_stimulus(1'b0, 1'b0, 3000, 1'b1, 100);

        #3;
        rst_n = 1'b0;
        #1;
        check_output("async_reset", S_FLUSH, 1'b1, 1'b0, 8'd0);
        mode_req = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply_stimulus(1'b1, 1'b0, 0, 1'b0, 15);
        check_output("post_reset_fl", S_FLUSH, 1'b1, 1'b0, 8'd0);
        apply_stimulus(1'b1, 1'b0, 0, 1'b0, 1);
        check_output("post_reset_acq", S_ACQ, 1'b1, 1'b0, 8'd0);

        rst2_n = 1'b1;
        repeat (2540) @(posedge clk);
        #1;
        check("sat_254", 32'(retry_cnt2), 32'd254);
        repeat (10) @(posedge clk);
        #1;
        check("sat_255", 32'(retry_cnt2), 32'd255);
        check("sat_pulse", 32'(acq_fail2), 32'd1);
        repeat (450) @(posedge clk);
        #1;
        check("sat_hold", 32'(retry_cnt2), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
